// File: rtl/axis_channel_router_if.sv
// Handshake and bus bundle for axis_channel_router: command port, AXIS input,
// fanned-out AXIS outputs and status.
interface axis_channel_router_if #(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned DATA_W = 256,
  parameter int unsigned LEN_W  = 16
);
  logic [NUM_CH-1:0] cmd_mask;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              abort;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [NUM_CH-1:0] m_axis_tvalid;
  logic [NUM_CH-1:0] m_axis_tready;
  logic              busy;
  logic [LEN_W-1:0]  beats_left;
  logic              cmd_err;
  logic              cmd_done;

  modport master (
    output cmd_mask, cmd_len, cmd_valid, abort, s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  cmd_ready, s_axis_tready, m_axis_tdata, m_axis_tvalid, busy, beats_left,
           cmd_err, cmd_done
  );

  modport slave (
    input  cmd_mask, cmd_len, cmd_valid, abort, s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output cmd_ready, s_axis_tready, m_axis_tdata, m_axis_tvalid, busy, beats_left,
           cmd_err, cmd_done
  );
endinterface

// File: rtl/axis_channel_router.sv
// AXI-Stream fan-out router: forwards a commanded number of input beats to every
// channel in a mask, tracking each channel's handshake independently.
module axis_channel_router #(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned DATA_W = 256,
  parameter int unsigned LEN_W  = 16
) (
  input logic                  pl_clk,
  input logic                  rst,
  axis_channel_router_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]  left_q, left_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              pend_next_empty;
  logic              cmd_ready_c;
  logic              in_ready;
  logic              in_hs;

  always_comb begin
    pend_next_empty = ((pend_q & ~bus.m_axis_tready) == '0);
    cmd_ready_c     = (state_q == IDLE) && !bus.abort;
    in_ready        = (state_q == RUN) && (left_q != '0) && pend_next_empty && !bus.abort;
    in_hs           = in_ready && bus.s_axis_tvalid;

    state_d = state_q;
    mask_d  = mask_q;
    pend_d  = pend_q & ~bus.m_axis_tready;
    data_d  = data_q;
    left_d  = left_q;
    err_d   = 1'b0;
    done_d  = 1'b0;

    if (state_q != IDLE && bus.abort) begin
      pend_d  = '0;
      left_d  = '0;
      state_d = IDLE;
      done_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_c) begin
            if (bus.cmd_mask == '0 || bus.cmd_len == '0) begin
              err_d = 1'b1;
            end else begin
              mask_d  = bus.cmd_mask;
              left_d  = bus.cmd_len;
              state_d = RUN;
            end
          end
        end
        RUN: begin
          // A load overrides any per-channel clear of the previous beat.
          if (in_hs) begin
            data_d = bus.s_axis_tdata;
            pend_d = mask_q;
            left_d = left_q - LEN_W'(1);
            if (left_q == LEN_W'(1)) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (pend_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge pl_clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      pend_q  <= '0;
      data_q  <= '0;
      left_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      left_q  <= left_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bus.cmd_ready     = cmd_ready_c;
  assign bus.s_axis_tready = in_ready;
  assign bus.m_axis_tdata  = data_q;
  assign bus.m_axis_tvalid = pend_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.beats_left    = left_q;
  assign bus.cmd_err       = err_q;
  assign bus.cmd_done      = done_q;
endmodule
